gcd_ctrl: RTL and testbench

Control FSM that sequences the subtractive GCD datapath, the counterpart of the datapath's control/status interface. It drives the datapath's load and mux selects (`ldA`, `ldB`, `sel1`, `sel2`, `sel_in`) and consumes its `gt`/`lt`/`eq` compare flags. It fetches two operands through a request/valid handshake, iterates subtractions until `eq`, then signals `done`; the result is read from the datapath's A register. An optional iteration watchdog aborts computations that do not converge.

---
 rtl/gcd_ctrl.sv | 118 +++++++++++
 tb/tb_gcd_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/gcd_ctrl.sv
// rtl/gcd_ctrl.sv - control FSM sequencing the subtractive GCD datapath
// Optional iteration watchdog: define GCD_CTRL_WATCHDOG_EN.
module gcd_ctrl #(
   parameter int unsigned          ITER_W   = 16,
   parameter logic [ITER_W-1:0]    MAX_ITER = {ITER_W{1'b1}}
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              op_valid_i,
   input  logic              gt_i,
   input  logic              lt_i,
   input  logic              eq_i,
   output logic              op_req_o,
   output logic              ldA_o,
   output logic              ldB_o,
   output logic              sel1_o,
   output logic              sel2_o,
   output logic              sel_in_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic [ITER_W-1:0] iter_count_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_B = 3'd2,
      S_RUN    = 3'd3,
      S_DONE   = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [ITER_W-1:0]   iter_q, iter_d;
   logic                busy_q, done_q, error_q;
   logic                wdog_hit;

`ifdef GCD_CTRL_WATCHDOG_EN
   assign wdog_hit = (iter_q == MAX_ITER);
`else
   logic unused_max_iter;
   assign unused_max_iter = ^MAX_ITER;
   assign wdog_hit        = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      iter_d   = iter_q;
      op_req_o = 1'b0;
      ldA_o    = 1'b0;
      ldB_o    = 1'b0;
      sel1_o   = 1'b0;
      sel2_o   = 1'b0;
      sel_in_o = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start_i) begin
               state_d = S_LOAD_A;
               iter_d  = '0;
            end
         end
         S_LOAD_A: begin
            op_req_o = 1'b1;
            sel_in_o = 1'b1;
            ldA_o    = op_valid_i;
            if (op_valid_i) state_d = S_LOAD_B;
         end
         S_LOAD_B: begin
            op_req_o = 1'b1;
            sel_in_o = 1'b1;
            ldB_o    = op_valid_i;
            if (op_valid_i) state_d = S_RUN;
         end
         S_RUN: begin
            if (eq_i) begin
               state_d = S_DONE;
            end else if (wdog_hit) begin
               // Abort cycle: no load, count frozen at the limit that tripped.
               state_d = S_ERR;
            end else begin
               if (iter_q != '1) iter_d = iter_q + ITER_W'(1);
               if (gt_i) begin
                  sel2_o = 1'b1;
                  ldA_o  = 1'b1;
               end else if (lt_i) begin
                  sel1_o = 1'b1;
                  ldB_o  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         iter_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         busy_q  <= (state_d == S_LOAD_A) || (state_d == S_LOAD_B) || (state_d == S_RUN);
         done_q  <= (state_d == S_DONE);
         error_q <= (state_d == S_ERR);
      end
   end

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign error_o      = error_q;
   assign iter_count_o = iter_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// tb/tb_gcd_ctrl.sv - scoreboard bench for gcd_ctrl with a behavioural GCD datapath
module tb_gcd_ctrl;

   localparam int          ITER_W = 16;
   localparam logic [15:0] MAX_IT = 16'd16;

   logic        clk = 1'b0;
   logic        rst, start, op_valid;
   logic [15:0] data_in;
   logic        gt, lt, eq;
   logic        op_req, ld_a, ld_b, sel1, sel2, sel_in, busy, done, error;
   logic [15:0] iter_count;

   always #5 clk = ~clk;

   gcd_ctrl #(.ITER_W(ITER_W), .MAX_ITER(MAX_IT)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .op_valid_i(op_valid),
      .gt_i(gt), .lt_i(lt), .eq_i(eq),
      .op_req_o(op_req), .ldA_o(ld_a), .ldB_o(ld_b), .sel1_o(sel1), .sel2_o(sel2),
      .sel_in_o(sel_in), .busy_o(busy), .done_o(done), .error_o(error),
      .iter_count_o(iter_count)
   );

   // Datapath model: A/B registers, subtractor, bus mux, comparator.
   logic [15:0] ra = 16'd0, rb = 16'd0;
   logic [15:0] sub, bus;
   always_comb begin
      sub = (sel1 ? rb : ra) - (sel2 ? rb : ra);
      bus = sel_in ? data_in : sub;
      gt  = ra > rb;
      lt  = ra < rb;
      eq  = ra == rb;
   end
   always @(posedge clk) begin
      if (ld_a) ra <= bus;
      if (ld_b) rb <= bus;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   typedef struct {
      int    res;
      int    iter;
      int    lat;
      bit    err;
      int    t0;
      string name;
   } exp_t;
   exp_t sb[$];

   exp_t mon_e;
   logic term_prev = 1'b0;
   always @(negedge clk) begin
      if (!rst && (done || error) && !term_prev) begin
         if (sb.size() == 0) begin
            chk("unexpected_termination", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk({mon_e.name, "_error"}, error, mon_e.err);
            chk({mon_e.name, "_done"}, done, !mon_e.err);
            chk({mon_e.name, "_iter"}, iter_count, mon_e.iter);
            chk({mon_e.name, "_latency"}, cyc - mon_e.t0, mon_e.lat);
            if (!mon_e.err) chk({mon_e.name, "_result"}, ra, mon_e.res);
         end
      end
      term_prev = done | error;
   end

   task automatic chk_all_zero(input string nm);
      chk({nm, "_outs"}, {op_req, ld_a, ld_b, sel1, sel2, sel_in, busy, done, error}, 0);
      chk({nm, "_iter"}, iter_count, 0);
   endtask

   // abort_n > 0: after operands load, run abort_n cycles, check progress, then reset.
   task automatic compute(input int a, input int b, input int sa, input int sbs,
                          input int exp_res, input int exp_iter, input int exp_lat,
                          input bit exp_err, input bit poke, input int abort_n,
                          input string name);
      exp_t e;
      int   t0;
      int   k;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      t0 = cyc;
      #1;
      chk({name, "_iter_cleared"}, iter_count, 0);
      chk({name, "_busy_load"}, {busy, done, error}, 3'b100);
      for (int i = 0; i < sa; i++) begin
         op_valid = 1'b0;
         #1;
         chk({name, "_stall_a"}, {op_req, ld_a, ld_b}, 3'b100);
         @(negedge clk);
      end
      op_valid = 1'b1; data_in = 16'(a);
      #1;
      chk({name, "_load_a"}, {op_req, sel_in, ld_a, ld_b}, 4'b1110);
      @(negedge clk);
      for (int i = 0; i < sbs; i++) begin
         op_valid = 1'b0;
         #1;
         chk({name, "_stall_b"}, {op_req, ld_a, ld_b}, 3'b100);
         @(negedge clk);
      end
      op_valid = 1'b1; data_in = 16'(b);
      #1;
      chk({name, "_load_b"}, {op_req, sel_in, ld_a, ld_b}, 4'b1101);
      @(negedge clk);
      op_valid = 1'b0;
      if (poke) begin
         start = 1'b1;
         @(negedge clk) start = 1'b0;
         chk({name, "_busy_after_poke"}, busy, 1);
      end
      if (abort_n > 0) begin
         repeat (abort_n) @(negedge clk);
         chk({name, "_busy_before_rst"}, {busy, done}, 2'b10);
         chk({name, "_iter_before_rst"}, iter_count, exp_iter);
         rst = 1'b1;
         @(negedge clk);
         chk_all_zero({name, "_after_rst"});
         rst = 1'b0;
      end else begin
         e.res = exp_res; e.iter = exp_iter; e.lat = exp_lat;
         e.err = exp_err; e.t0 = t0; e.name = name;
         sb.push_back(e);
         k = 0;
         while (!(done || error) && k < 300) begin
            @(negedge clk);
            k++;
         end
         if (k >= 300) chk({name, "_timeout"}, 0, 1);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op_valid = 1'b0; data_in = 16'd0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      compute(12, 8,  0, 0, 4, 2, 5,  0, 0, 0, "g12_8");
      compute(7,  7,  0, 0, 7, 0, 3,  0, 0, 0, "g7_7");
      compute(12, 8,  3, 2, 4, 2, 10, 0, 0, 0, "g12_8_stall");
      compute(48, 18, 0, 0, 6, 4, 7,  0, 1, 0, "g48_18_poke");
      compute(9,  27, 0, 0, 9, 2, 5,  0, 0, 0, "g9_27");
      compute(48, 18, 0, 0, 0, 2, 0,  0, 0, 2, "g48_18_abort");
      compute(48, 18, 0, 0, 6, 4, 7,  0, 0, 0, "g48_18_after_rst");
`ifdef GCD_CTRL_WATCHDOG_EN
      compute(0,  5,  0, 0, 0, 16, 19, 1, 0, 0, "zero_wdog");
`else
      compute(0,  5,  0, 0, 0, 16'hFFFF, 0, 0, 0, 65600, "zero_sat");
`endif

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
